// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: request payload and
// write-source encoding.
package writeback_arbiter_pkg;

   localparam int unsigned DestW = 5;
   localparam int unsigned DataW = 32;

   typedef struct packed {
      logic [DestW-1:0] dest;
      logic [DataW-1:0] data;
   } wb_req_t;

   localparam logic [DestW-1:0] RegZero = 5'd0;

   typedef enum logic {
      WbSrcP0 = 1'b0,
      WbSrcP1 = 1'b1
   } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Synchronous FIFO buffering long-latency writeback requests. No bypass: a
// pushed entry is visible at the head only from the following cycle.
module writeback_arbiter_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  wb_req_t         wdata_i,
   input  logic            pop_i,
   output wb_req_t         rdata_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   wb_req_t         mem_q [Depth];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            do_push;
   logic            do_pop;

   always_comb begin
      full    = (count_q == CntW'(Depth));
      empty_o = (count_q == '0);
      do_push = push_i & ~full;
      do_pop  = pop_i & ~empty_o;
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is qualified by the pointers/count, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single regfile write port between the in-order pipe (port 0)
// and the buffered long-latency unit (port 1), with starvation and WAW guards.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned FifoDepth   = 2,
   parameter int unsigned StarveLimit = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             p0_valid_i,
   input  logic [DestW-1:0] p0_dest_i,
   input  logic [DataW-1:0] p0_data_i,
   output logic             p0_ready_o,
   input  logic             p1_valid_i,
   input  logic [DestW-1:0] p1_dest_i,
   input  logic [DataW-1:0] p1_data_i,
   output logic             p1_ready_o,
   output logic             reg_write_en_o,
   output logic [DestW-1:0] reg_write_dest_o,
   output logic [DataW-1:0] reg_write_data_o,
   output logic             wb_src_o,
   output logic             p1_pending_o
);

   localparam int unsigned CntW    = $clog2(FifoDepth) + 1;
   localparam int unsigned StarveW = 4;

   wb_req_t            p1_req;
   wb_req_t            head;
   logic               fifo_empty;
   logic [CntW-1:0]    fifo_count;
   logic               push;
   logic               forced;
   logic               waw;
   logic               grant_p0;
   logic               grant_p1;

   logic [StarveW-1:0] starve_q, starve_d;
   logic               en_q, en_d;
   logic [DestW-1:0]   dest_q, dest_d;
   logic [DataW-1:0]   data_q, data_d;
   wb_src_e            src_q, src_d;

   assign p1_req     = '{dest: p1_dest_i, data: p1_data_i};
   assign p1_ready_o = (fifo_count < CntW'(FifoDepth));
   assign push       = p1_valid_i & p1_ready_o;

   writeback_arbiter_fifo #(
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (p1_req),
      .pop_i   (grant_p1),
      .rdata_o (head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      forced   = ~fifo_empty && (starve_q == StarveW'(StarveLimit));
      // The buffered result is older, so it must land before a same-dest p0 write.
      waw      = ~fifo_empty && p0_valid_i && (head.dest == p0_dest_i) &&
                 (p0_dest_i != RegZero);
      grant_p0 = p0_valid_i && !forced && !waw;
      grant_p1 = ~fifo_empty && !grant_p0;

      if (fifo_empty || grant_p1) begin
         starve_d = '0;
      end else if (starve_q != StarveW'(StarveLimit)) begin
         starve_d = starve_q + 1'b1;
      end else begin
         starve_d = starve_q;
      end

      en_d   = 1'b0;
      dest_d = dest_q;
      data_d = data_q;
      src_d  = src_q;
      if (grant_p0) begin
         en_d   = (p0_dest_i != RegZero);
         dest_d = p0_dest_i;
         data_d = p0_data_i;
         src_d  = WbSrcP0;
      end else if (grant_p1) begin
         en_d   = (head.dest != RegZero);
         dest_d = head.dest;
         data_d = head.data;
         src_d  = WbSrcP1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         starve_q <= '0;
         en_q     <= 1'b0;
         dest_q   <= '0;
         data_q   <= '0;
         src_q    <= WbSrcP0;
      end else begin
         starve_q <= starve_d;
         en_q     <= en_d;
         dest_q   <= dest_d;
         data_q   <= data_d;
         src_q    <= src_d;
      end
   end

   assign p0_ready_o       = grant_p0;
   assign reg_write_en_o   = en_q;
   assign reg_write_dest_o = dest_q;
   assign reg_write_data_o = data_q;
   assign wb_src_o         = src_q;
   assign p1_pending_o     = ~fifo_empty;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (FifoDepth=2, StarveLimit=4).
module tb_writeback_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        p0_valid_i;
   logic [4:0]  p0_dest_i;
   logic [31:0] p0_data_i;
   logic        p0_ready_o;
   logic        p1_valid_i;
   logic [4:0]  p1_dest_i;
   logic [31:0] p1_data_i;
   logic        p1_ready_o;
   logic        reg_write_en_o;
   logic [4:0]  reg_write_dest_o;
   logic [31:0] reg_write_data_o;
   logic        wb_src_o;
   logic        p1_pending_o;

   logic [38:0] wb_obs;
   int          n_checks = 0;
   int          n_fail   = 0;

   assign wb_obs = {reg_write_en_o, reg_write_dest_o, reg_write_data_o, wb_src_o};

   always #5 clk_i = ~clk_i;

   writeback_arbiter #(
      .FifoDepth   (2),
      .StarveLimit (4)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .p0_valid_i       (p0_valid_i),
      .p0_dest_i        (p0_dest_i),
      .p0_data_i        (p0_data_i),
      .p0_ready_o       (p0_ready_o),
      .p1_valid_i       (p1_valid_i),
      .p1_dest_i        (p1_dest_i),
      .p1_data_i        (p1_data_i),
      .p1_ready_o       (p1_ready_o),
      .reg_write_en_o   (reg_write_en_o),
      .reg_write_dest_o (reg_write_dest_o),
      .reg_write_data_o (reg_write_data_o),
      .wb_src_o         (wb_src_o),
      .p1_pending_o     (p1_pending_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      p0_valid_i = 1'b0;
      p0_dest_i  = '0;
      p0_data_i  = '0;
      p1_valid_i = 1'b0;
      p1_dest_i  = '0;
      p1_data_i  = '0;
   endtask

   task automatic test_reset();
      rst_ni     = 1'b0;
      p0_valid_i = 1'b1; p0_dest_i = 5'd3; p0_data_i = 32'hDEAD;
      p1_valid_i = 1'b1; p1_dest_i = 5'd5; p1_data_i = 32'hBEEF;
      tick();
      tick();
      n_checks++;
      if (wb_obs !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h exp %h", wb_obs, 39'd0);
      end
      n_checks++;
      if ({p1_ready_o, p1_pending_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_p1_flags: got ready=%b pending=%b exp ready=1 pending=0",
                  p1_ready_o, p1_pending_o);
      end
      idle_inputs();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_p0_only();
      p0_valid_i = 1'b1; p0_dest_i = 5'd3; p0_data_i = 32'h11;
      #1;
      n_checks++;
      if (p0_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL p0_only_ready: got %b exp 1", p0_ready_o);
      end
      tick();
      p0_valid_i = 1'b0;
      n_checks++;
      if (wb_obs !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL p0_only_write: got %h exp %h", wb_obs, {1'b1, 5'd3, 32'h11, 1'b0});
      end
      tick();
      n_checks++;
      if (wb_obs !== {1'b0, 5'd3, 32'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL p0_only_idle_hold: got %h exp %h", wb_obs, {1'b0, 5'd3, 32'h11, 1'b0});
      end
   endtask

   task automatic test_p1_only();
      p1_valid_i = 1'b1; p1_dest_i = 5'd5; p1_data_i = 32'hAB;
      tick();
      p1_valid_i = 1'b0;
      n_checks++;
      if ({reg_write_en_o, p1_pending_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL p1_only_buffered: got en=%b pending=%b exp en=0 pending=1",
                  reg_write_en_o, p1_pending_o);
      end
      tick();
      n_checks++;
      if (wb_obs !== {1'b1, 5'd5, 32'hAB, 1'b1}) begin
         n_fail++;
         $display("FAIL p1_only_write: got %h exp %h", wb_obs, {1'b1, 5'd5, 32'hAB, 1'b1});
      end
      n_checks++;
      if (p1_pending_o !== 1'b0) begin
         n_fail++;
         $display("FAIL p1_only_drained: got pending=%b exp 0", p1_pending_o);
      end
      tick();
   endtask

   task automatic test_starvation();
      p0_valid_i = 1'b1; p0_dest_i = 5'd1; p0_data_i = 32'h100;
      p1_valid_i = 1'b1; p1_dest_i = 5'd9; p1_data_i = 32'h99;
      tick();
      p1_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         p0_data_i = 32'h100 + 32'(k);
         tick();
         n_checks++;
         if (wb_obs !== {1'b1, 5'd1, 32'h100 + 32'(k), 1'b0}) begin
            n_fail++;
            $display("FAIL starve_p0_write%0d: got %h exp %h", k, wb_obs,
                     {1'b1, 5'd1, 32'h100 + 32'(k), 1'b0});
         end
      end
      n_checks++;
      if ({p0_ready_o, p1_pending_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL starve_forced_ready: got ready=%b pending=%b exp ready=0 pending=1",
                  p0_ready_o, p1_pending_o);
      end
      tick();
      n_checks++;
      if (wb_obs !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
         n_fail++;
         $display("FAIL starve_p1_write: got %h exp %h", wb_obs, {1'b1, 5'd9, 32'h99, 1'b1});
      end
      n_checks++;
      if (p0_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_p0_resume: got %b exp 1", p0_ready_o);
      end
      tick();
      p0_valid_i = 1'b0;
      n_checks++;
      if (wb_obs !== {1'b1, 5'd1, 32'h103, 1'b0}) begin
         n_fail++;
         $display("FAIL starve_p0_after: got %h exp %h", wb_obs, {1'b1, 5'd1, 32'h103, 1'b0});
      end
      tick();
   endtask

   task automatic test_waw();
      p1_valid_i = 1'b1; p1_dest_i = 5'd7; p1_data_i = 32'h1;
      tick();
      p1_valid_i = 1'b0;
      p0_valid_i = 1'b1; p0_dest_i = 5'd7; p0_data_i = 32'h2;
      #1;
      n_checks++;
      if (p0_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL waw_p0_blocked: got %b exp 0", p0_ready_o);
      end
      tick();
      n_checks++;
      if (wb_obs !== {1'b1, 5'd7, 32'h1, 1'b1}) begin
         n_fail++;
         $display("FAIL waw_first_write: got %h exp %h", wb_obs, {1'b1, 5'd7, 32'h1, 1'b1});
      end
      tick();
      p0_valid_i = 1'b0;
      n_checks++;
      if (wb_obs !== {1'b1, 5'd7, 32'h2, 1'b0}) begin
         n_fail++;
         $display("FAIL waw_second_write: got %h exp %h", wb_obs, {1'b1, 5'd7, 32'h2, 1'b0});
      end
      tick();
   endtask

   task automatic test_full_dest0();
      p0_valid_i = 1'b1; p0_dest_i = 5'd2; p0_data_i = 32'h22;
      p1_valid_i = 1'b1; p1_dest_i = 5'd10; p1_data_i = 32'hA0;
      tick();
      p1_dest_i = 5'd11; p1_data_i = 32'hB0;
      tick();
      p1_dest_i = 5'd12; p1_data_i = 32'hC0;
      p0_dest_i = 5'd0;  p0_data_i = 32'h55;
      #1;
      n_checks++;
      if ({p1_ready_o, p0_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL full_third_push: got p1_ready=%b p0_ready=%b exp p1_ready=0 p0_ready=1",
                  p1_ready_o, p0_ready_o);
      end
      tick();
      p0_valid_i = 1'b0;
      n_checks++;
      if (wb_obs !== {1'b0, 5'd0, 32'h55, 1'b0}) begin
         n_fail++;
         $display("FAIL dest0_no_write: got %h exp %h", wb_obs, {1'b0, 5'd0, 32'h55, 1'b0});
      end
      n_checks++;
      if (p1_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop_no_bypass: got %b exp 0", p1_ready_o);
      end
      tick();
      n_checks++;
      if ({wb_obs, p1_ready_o} !== {1'b1, 5'd10, 32'hA0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL full_drain0: got %h exp %h", {wb_obs, p1_ready_o},
                  {1'b1, 5'd10, 32'hA0, 1'b1, 1'b1});
      end
      tick();
      p1_valid_i = 1'b0;
      n_checks++;
      if (wb_obs !== {1'b1, 5'd11, 32'hB0, 1'b1}) begin
         n_fail++;
         $display("FAIL full_drain1: got %h exp %h", wb_obs, {1'b1, 5'd11, 32'hB0, 1'b1});
      end
      tick();
      n_checks++;
      if (wb_obs !== {1'b1, 5'd12, 32'hC0, 1'b1}) begin
         n_fail++;
         $display("FAIL full_drain2: got %h exp %h", wb_obs, {1'b1, 5'd12, 32'hC0, 1'b1});
      end
      tick();
      n_checks++;
      if ({reg_write_en_o, p1_pending_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL full_empty_after: got en=%b pending=%b exp 0 0",
                  reg_write_en_o, p1_pending_o);
      end
   endtask

   task automatic test_reset_mid();
      p0_valid_i = 1'b1; p0_dest_i = 5'd6; p0_data_i = 32'h66;
      p1_valid_i = 1'b1; p1_dest_i = 5'd4; p1_data_i = 32'h44;
      tick();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      n_checks++;
      if ({wb_obs, p1_pending_o} !== 40'd0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: got %h exp %h", {wb_obs, p1_pending_o}, 40'd0);
      end
      rst_ni = 1'b1;
      tick();
      n_checks++;
      if ({reg_write_en_o, p1_pending_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_dropped: got en=%b pending=%b exp 0 0",
                  reg_write_en_o, p1_pending_o);
      end
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      test_reset();
      test_p0_only();
      test_p1_only();
      test_starvation();
      test_waw();
      test_full_dest0();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
